osc_measure_ctrl: RTL and testbench
===================================

OSC_MEASURE_CTRL -- requirements
Module: osc_measure_ctrl

Interface
REQ-001 SHALL provide parameter GATE_W, default 16, width of gate-length field.
REQ-002 SHALL provide parameter CNT_W, default 16, width of edge counter.
REQ-003 SHALL provide parameter SETTLE, default 4, clk cycles between enabling the oscillator and the start of counting.
REQ-004 SHALL provide parameter SYNC_STAGES, default 2, flip-flops in the osc_in synchronizer (minimum 2).
REQ-005 clk  input  1  single system clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  request a measurement; sampled only in IDLE.
REQ-008 abort  input  1  cancel a measurement in progress.
REQ-009 gate_len  input  GATE_W  measurement window in clk cycles; captured on an accepted start.
REQ-010 osc_en  output  1  enable to the gated ring oscillator.
REQ-011 osc_in  input  1  asynchronous oscillator output.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse when a result is valid.
REQ-014 count  output  CNT_W  rising edges of osc_in counted in the last completed window.
REQ-015 overflow  output  1  high when the last completed window saturated count.

Function
REQ-016 SHALL implement the states IDLE, ARM, MEASURE, DRAIN and DONE.
REQ-017 IDLE: when start=1 and abort=0, SHALL capture gate_len, clear the working counter and the working overflow flag, and go to ARM.
REQ-018 ARM: SHALL hold osc_en=1 for exactly SETTLE cycles, then go to MEASURE; no edges are counted in ARM.
REQ-019 MEASURE: SHALL stay for exactly the captured gate_len cycles and count each synchronized rising edge of osc_in seen in those cycles.
REQ-020 SHALL then go to DRAIN, with osc_en=0 from the first DRAIN cycle onward.
REQ-021 DRAIN: SHALL last SYNC_STAGES cycles, counting nothing, then go to DONE.
REQ-022 DONE: SHALL last one cycle with done=1, copy the working counter to count and the working flag to overflow, then return to IDLE.
REQ-023 osc_en SHALL be 1 only in ARM and MEASURE.
REQ-024 Latency: if start is accepted at edge k, done SHALL be high in cycle k+1+SETTLE+gate_len+SYNC_STAGES.
REQ-025 gate_len=0 SHALL go from ARM directly to DRAIN, giving count=0 and overflow=0.
REQ-026 The working counter SHALL saturate at 2^CNT_W-1 and set the working overflow flag; it SHALL never wrap.
REQ-027 A rising edge is sync[last]=1 while the previous sample was 0, taken after the SYNC_STAGES synchronizer; at most one edge is counted per clk.
REQ-028 start SHALL be ignored while busy=1.
REQ-029 abort=1 in ARM, MEASURE or DRAIN SHALL return to IDLE on the next edge with osc_en=0 and no done pulse; count and overflow keep their previous values.
REQ-030 abort=1 together with start=1 in IDLE SHALL keep the block in IDLE; abort wins.
REQ-031 count and overflow SHALL change only in DONE or on reset.

Reset
REQ-032 rst_n=0 SHALL immediately force the state to IDLE and osc_en, busy, done, count, overflow, the working counter and the synchronizer flops to 0, independent of clk.
REQ-033 Reset asserted in the middle of a measurement SHALL discard that measurement; after release the block SHALL accept a new start in the first clk cycle.

Structure
REQ-034 A shared package osc_ctrl_pkg SHALL hold the state enumeration and the default values of GATE_W, CNT_W, SETTLE and SYNC_STAGES.
REQ-035 The synchronizer and rising-edge detector SHALL be a single sub-module, sync_edge, parameterized by SYNC_STAGES, with the same clk and rst_n.
REQ-036 The gate and settle down-counters and the FSM SHALL reside in osc_measure_ctrl.

Verification
REQ-037 Default parameters, osc_in a square wave with 4-clk period, gate_len=40, start pulse -> done one cycle at the latency of REQ-024, count=10, overflow=0.
REQ-038 gate_len=0 -> osc_en high for exactly SETTLE cycles, count=0, overflow=0, done 1+SETTLE+SYNC_STAGES cycles after start.
REQ-039 CNT_W=4, osc_in with 2-clk period, gate_len=100 -> count=15, overflow=1; a following run with gate_len=8 -> count=4, overflow=0.
REQ-040 abort in MEASURE cycle 5 -> osc_en=0 and busy=0 next cycle, no done pulse, count keeps its prior value.
REQ-041 start re-pulsed during MEASURE -> ignored; exactly one done pulse.
REQ-042 rst_n low mid-MEASURE -> all outputs 0 without a clk edge; a start after release completes normally.

Source files
------------

// File: rtl/osc_ctrl_pkg.sv
// Shared definitions for the ring-oscillator measurement controller:
// FSM state encoding and default parameter values.
package osc_ctrl_pkg;

  localparam int GATE_W_DEF      = 16;
  localparam int CNT_W_DEF       = 16;
  localparam int SETTLE_DEF      = 4;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_MEASURE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for the asynchronous oscillator output followed by a
// rising-edge detector; rise is high for one clk per detected edge.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic osc_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], osc_in};
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign rise = sync_reg[SYNC_STAGES-1] & ~prev_reg;

endmodule

// File: rtl/osc_measure_ctrl.sv
// Gated ring-oscillator frequency measurement: enables the oscillator, lets it
// settle, counts synchronized rising edges for gate_len clk cycles, then reports.
module osc_measure_ctrl
  import osc_ctrl_pkg::*;
#(
  parameter int GATE_W      = GATE_W_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SETTLE      = SETTLE_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [GATE_W-1:0] gate_len,
  output logic              osc_en,
  input  logic              osc_in,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic              overflow
);

  // One phase counter times both the settle period and the drain period.
  localparam int PHASE_W = $clog2(max_int(SETTLE, SYNC_STAGES) + 1);
  localparam logic [PHASE_W-1:0] SETTLE_LAST = PHASE_W'(SETTLE - 1);
  localparam logic [PHASE_W-1:0] DRAIN_LAST  = PHASE_W'(SYNC_STAGES - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX     = {CNT_W{1'b1}};

  state_t              state_reg;
  logic [GATE_W-1:0]   gate_cnt_reg;
  logic [PHASE_W-1:0]  phase_cnt_reg;
  logic [CNT_W-1:0]    work_cnt_reg;
  logic                work_ovf_reg;
  logic                rise;

  sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .osc_in(osc_in),
    .rise  (rise)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      gate_cnt_reg  <= '0;
      phase_cnt_reg <= '0;
      work_cnt_reg  <= '0;
      work_ovf_reg  <= 1'b0;
      osc_en        <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      count         <= '0;
      overflow      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && (state_reg == ST_ARM || state_reg == ST_MEASURE ||
                    state_reg == ST_DRAIN)) begin
        state_reg <= ST_IDLE;
        osc_en    <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (start && !abort) begin
              state_reg     <= ST_ARM;
              gate_cnt_reg  <= gate_len;
              phase_cnt_reg <= SETTLE_LAST;
              work_cnt_reg  <= '0;
              work_ovf_reg  <= 1'b0;
              osc_en        <= 1'b1;
              busy          <= 1'b1;
            end
          end
          ST_ARM: begin
            if (phase_cnt_reg == '0) begin
              if (gate_cnt_reg == '0) begin
                state_reg     <= ST_DRAIN;
                phase_cnt_reg <= DRAIN_LAST;
                osc_en        <= 1'b0;
              end else begin
                state_reg <= ST_MEASURE;
              end
            end else begin
              phase_cnt_reg <= phase_cnt_reg - PHASE_W'(1);
            end
          end
          ST_MEASURE: begin
            // Saturate instead of wrapping; the flag records a dropped edge.
            if (rise) begin
              if (work_cnt_reg == CNT_MAX) work_ovf_reg <= 1'b1;
              else                         work_cnt_reg <= work_cnt_reg + CNT_W'(1);
            end
            if (gate_cnt_reg == GATE_W'(1)) begin
              state_reg     <= ST_DRAIN;
              phase_cnt_reg <= DRAIN_LAST;
              osc_en        <= 1'b0;
            end else begin
              gate_cnt_reg <= gate_cnt_reg - GATE_W'(1);
            end
          end
          ST_DRAIN: begin
            if (phase_cnt_reg == '0) begin
              state_reg <= ST_DONE;
              done      <= 1'b1;
              count     <= work_cnt_reg;
              overflow  <= work_ovf_reg;
            end else begin
              phase_cnt_reg <= phase_cnt_reg - PHASE_W'(1);
            end
          end
          ST_DONE: begin
            state_reg <= ST_IDLE;
            busy      <= 1'b0;
          end
          default: begin
            state_reg <= ST_IDLE;
            osc_en    <= 1'b0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_osc_measure_ctrl.sv
// Bench for osc_measure_ctrl: a default instance and a 4-bit-counter instance
// share stimulus and are checked cycle by cycle against a timeline/edge model.
module tb_osc_measure_ctrl;

  localparam int GATE_W = 16;
  localparam int SETTLE = 4;
  localparam int SS     = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              osc_in = 1'b0;
  logic [GATE_W-1:0] gate_len = '0;

  logic        osc_en_a, busy_a, done_a, overflow_a;
  logic [15:0] count_a;
  logic        osc_en_b, busy_b, done_b, overflow_b;
  logic [3:0]  count_b;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int mode = 0;
  int period = 4;
  int phase = 0;
  bit hist [0:39999];

  logic [15:0] prev_cnt_a = '0;
  logic        prev_ovf_a = 1'b0;
  logic [3:0]  prev_cnt_b = '0;
  logic        prev_ovf_b = 1'b0;

  osc_measure_ctrl #(
    .GATE_W(GATE_W), .CNT_W(16), .SETTLE(SETTLE), .SYNC_STAGES(SS)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .gate_len(gate_len),
    .osc_en(osc_en_a), .osc_in(osc_in), .busy(busy_a), .done(done_a),
    .count(count_a), .overflow(overflow_a)
  );

  osc_measure_ctrl #(
    .GATE_W(GATE_W), .CNT_W(4), .SETTLE(SETTLE), .SYNC_STAGES(SS)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .gate_len(gate_len),
    .osc_en(osc_en_b), .osc_in(osc_in), .busy(busy_b), .done(done_b),
    .count(count_b), .overflow(overflow_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Oscillator stand-in; hist[c] is the level held during cycle c.
  always @(posedge clk) begin
    #2;
    case (mode)
      0:       osc_in = 1'b0;
      1:       osc_in = (((cyc + phase) % period) < (period / 2));
      default: osc_in = 1'($urandom_range(0, 1));
    endcase
    if (cyc < 40000) hist[cyc] = osc_in;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_all(input logic eb, input logic ee, input logic ed);
    chk("busy_a", 32'(busy_a), 32'(eb));
    chk("busy_b", 32'(busy_b), 32'(eb));
    chk("osc_en_a", 32'(osc_en_a), 32'(ee));
    chk("osc_en_b", 32'(osc_en_b), 32'(ee));
    chk("done_a", 32'(done_a), 32'(ed));
    chk("done_b", 32'(done_b), 32'(ed));
    chk("count_a", 32'(count_a), 32'(prev_cnt_a));
    chk("count_b", 32'(count_b), 32'(prev_cnt_b));
    chk("overflow_a", 32'(overflow_a), 32'(prev_ovf_a));
    chk("overflow_b", 32'(overflow_b), 32'(prev_ovf_b));
  endtask

  // Edges seen in the window: a synchronized sample is the input SS cycles earlier.
  function automatic int model_edges(input int first, input int last);
    int e = 0;
    for (int c = first; c <= last; c++)
      if (hist[c-SS] && !hist[c-SS-1]) e++;
    return e;
  endfunction

  // One measurement with start high in cycle k; optional abort or start
  // re-pulse at relative cycle k+SETTLE+m (m=1 is the first MEASURE cycle).
  task automatic run(input int g, input bit do_ab, input int ab_m,
                     input bit do_re, input int re_m);
    int k, d, a_end, en_end, e;
    @(negedge clk);
    k      = cyc;
    d      = k + 1 + SETTLE + g + SS;
    a_end  = do_ab ? k + SETTLE + ab_m : d;
    en_end = (k + SETTLE + g < a_end) ? k + SETTLE + g : a_end;
    e      = -1;
    while (1) begin
      if (!do_ab && cyc == d) begin
        e = model_edges(k + SETTLE + 1, k + SETTLE + g);
        prev_cnt_a = 16'((e > 65535) ? 65535 : e);
        prev_ovf_a = (e > 65535);
        prev_cnt_b = 4'((e > 15) ? 15 : e);
        prev_ovf_b = (e > 15);
      end
      chk_all((cyc >= k + 1 && cyc <= a_end), (cyc >= k + 1 && cyc <= en_end),
              (!do_ab && cyc == d));
      start = (cyc == k) || (do_re && cyc == k + SETTLE + re_m);
      abort = do_ab && (cyc == k + SETTLE + ab_m);
      if (cyc == k)     gate_len = GATE_W'(g);
      if (cyc == k + 1) gate_len = GATE_W'($urandom);
      if (cyc >= a_end + 2) break;
      @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
    $display("run gate=%0d abort=%0d restart=%0d edges=%0d count_a=%0d ovf_a=%0d count_b=%0d ovf_b=%0d",
             g, do_ab, do_re, e, count_a, overflow_a, count_b, overflow_b);
  endtask

  initial begin
    int g, sel, m;

    // Reset state
    @(negedge clk);
    chk_all(1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Nominal window: 4-clk square wave, 40-cycle gate
    mode = 1; period = 4; phase = 0;
    run(40, 0, 0, 0, 0);
    // Zero-length gate
    run(0, 0, 0, 0, 0);
    // Saturation on the 4-bit instance, then a short clean window
    period = 2;
    run(100, 0, 0, 0, 0);
    run(8, 0, 0, 0, 0);
    // Abort in MEASURE cycle 5, start re-pulsed during MEASURE
    period = 4; phase = 1;
    run(40, 1, 5, 0, 0);
    run(40, 0, 0, 1, 10);

    // abort together with start in IDLE stays idle
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk_all(1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk_all(1'b0, 1'b0, 1'b0);

    // Reset in MEASURE cycle 5, then a start in the first cycle after release
    mode = 0;
    @(negedge clk);
    gate_len = 16'd30; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (SETTLE + 4) @(negedge clk);
    chk("busy_mid_a", 32'(busy_a), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    prev_cnt_a = '0; prev_ovf_a = 1'b0; prev_cnt_b = '0; prev_ovf_b = 1'b0;
    chk_all(1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    mode = 1; period = 6; phase = 2;
    run(20, 0, 0, 0, 0);

    // Randomized runs
    for (int i = 0; i < 30; i++) begin
      mode   = int'($urandom_range(1, 2));
      period = 2 * int'($urandom_range(1, 5));
      phase  = int'($urandom_range(0, 9));
      g      = int'($urandom_range(0, 60));
      sel    = int'($urandom_range(0, 3));
      if (sel == 0) begin
        m = int'($urandom_range(0, g + SETTLE + SS - 1)) - SETTLE + 1;
        run(g, 1, m, 0, 0);
      end else if (sel == 1 && g > 0) begin
        m = int'($urandom_range(1, g));
        run(g, 0, 0, 1, m);
      end else begin
        run(g, 0, 0, 0, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
